// File: rtl/midi_note_rx.sv
// midi_note_rx: MIDI serial byte receiver and Note On/Off message parser.
// The line idles low, the start bit is high and data arrives MSB first.
// Optional feature macro: MIDI_RUNNING_STATUS_EN. It keeps the last note
// status, so a data byte that arrives after a complete message is read
// as a new key under that status.
module midi_note_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       note_valid,
  output logic       note_on,
  output logic [3:0] note_chan,
  output logic [6:0] note_key,
  output logic [6:0] note_vel
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_KEY, P_WAIT_VEL} p_state_e;

  // Synchronizer, edge detector and byte receiver
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_byte_valid_q, frame_err_q;

  // Parser
  p_state_e   p_state_q;
  logic       cur_on_q;
  logic [3:0] cur_chan_q;
  logic [6:0] cur_key_q;
  logic       note_valid_q, note_on_q;
  logic [3:0] note_chan_q;
  logic [6:0] note_key_q, note_vel_q;
`ifdef MIDI_RUNNING_STATUS_EN
  logic       rs_valid_q;
`endif

  logic rise;
  assign rise = rx_s2_q & ~rx_prev_q;

  // Byte receiver: synchronize rx, detect the start edge, sample mid-bit
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q         <= 1'b0;
      rx_s2_q         <= 1'b0;
      rx_prev_q       <= 1'b0;
      rx_state_q      <= RX_IDLE;
      cnt_q           <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      rx_s1_q         <= rx;
      rx_s2_q         <= rx_s1_q;
      rx_prev_q       <= rx_s2_q;
      rx_byte_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          cnt_q     <= '0;
          bit_cnt_q <= '0;
          if (rise) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q      <= '0;
            // A start bit that is already gone by mid-bit is a glitch.
            rx_state_q <= rx_s2_q ? RX_DATA : RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {shift_q[6:0], rx_s2_q};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q      <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s2_q) begin
              rx_byte_q       <= shift_q;
              rx_byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Parser: assemble status/key/velocity and emit one registered note event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q    <= P_WAIT_STATUS;
      cur_on_q     <= 1'b0;
      cur_chan_q   <= '0;
      cur_key_q    <= '0;
      note_valid_q <= 1'b0;
      note_on_q    <= 1'b0;
      note_chan_q  <= '0;
      note_key_q   <= '0;
      note_vel_q   <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
      rs_valid_q   <= 1'b0;
`endif
    end else begin
      note_valid_q <= 1'b0;
      if (frame_err_q) begin
        p_state_q  <= P_WAIT_STATUS;
`ifdef MIDI_RUNNING_STATUS_EN
        rs_valid_q <= 1'b0;
`endif
      end else if (rx_byte_valid_q) begin
        if (rx_byte_q[7:3] == 5'b11111) begin
          // Realtime bytes may interleave anywhere; they leave the parse intact.
        end else if (rx_byte_q[7:5] == 3'b100) begin
          cur_on_q   <= rx_byte_q[4];
          cur_chan_q <= rx_byte_q[3:0];
          p_state_q  <= P_WAIT_KEY;
`ifdef MIDI_RUNNING_STATUS_EN
          rs_valid_q <= 1'b1;
`endif
        end else if (rx_byte_q[7]) begin
          p_state_q  <= P_WAIT_STATUS;
`ifdef MIDI_RUNNING_STATUS_EN
          rs_valid_q <= 1'b0;
`endif
        end else begin
          case (p_state_q)
            P_WAIT_STATUS: begin
`ifdef MIDI_RUNNING_STATUS_EN
              if (rs_valid_q) begin
                cur_key_q <= rx_byte_q[6:0];
                p_state_q <= P_WAIT_VEL;
              end
`endif
            end
            P_WAIT_KEY: begin
              cur_key_q <= rx_byte_q[6:0];
              p_state_q <= P_WAIT_VEL;
            end
            P_WAIT_VEL: begin
              // Note On with velocity 0 is a Note Off by MIDI convention.
              note_valid_q <= 1'b1;
              note_on_q    <= cur_on_q & (rx_byte_q[6:0] != 7'd0);
              note_chan_q  <= cur_chan_q;
              note_key_q   <= cur_key_q;
              note_vel_q   <= rx_byte_q[6:0];
              p_state_q    <= P_WAIT_STATUS;
            end
            default: p_state_q <= P_WAIT_STATUS;
          endcase
        end
      end
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign frame_err     = frame_err_q;
  assign note_valid    = note_valid_q;
  assign note_on       = note_on_q;
  assign note_chan     = note_chan_q;
  assign note_key      = note_key_q;
  assign note_vel      = note_vel_q;

endmodule

// File: tb/tb_midi_note_rx.sv
// tb_midi_note_rx: directed frames with a scoreboard of expected bytes and
// note events. A negedge monitor pops and compares whenever a strobe fires.
module tb_midi_note_rx;

  localparam int CPB = 16;   // 320 kHz / 20 kbaud

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, frame_err, note_valid, note_on;
  logic [3:0] note_chan;
  logic [6:0] note_key, note_vel;

  midi_note_rx #(.CLK_HZ(320_000), .BAUD(20_000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .frame_err(frame_err),
    .note_valid(note_valid), .note_on(note_on), .note_chan(note_chan),
    .note_key(note_key), .note_vel(note_vel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       on;
    logic [3:0] chan;
    logic [6:0] key;
    logic [6:0] vel;
  } note_t;

  localparam int FERR = 256;   // scoreboard code for an expected frame error

  int    byte_exp_q[$];
  note_t note_exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops expectations on every strobe, checks strobe width and
  // that note fields never move without note_valid.
  note_t last_note, cur_note, exp_note;
  logic  prev_rbv, prev_nv;
  int    exp_byte, act_byte;

  always @(negedge clk) begin
    cur_note = {note_on, note_chan, note_key, note_vel};
    if (!rst_n) begin
      last_note = '0;
      prev_rbv  = 1'b0;
      prev_nv   = 1'b0;
    end else begin
      if (rx_byte_valid || frame_err) begin
        act_byte = (rx_byte_valid && frame_err) ? 512 : (frame_err ? FERR : int'(rx_byte));
        check("byte_strobe_width", {31'd0, prev_rbv}, 32'd0);
        if (byte_exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte strobe at %0t", act_byte, $time);
        end else begin
          exp_byte = byte_exp_q.pop_front();
          check("rx_byte", act_byte, exp_byte);
        end
      end
      if (note_valid) begin
        check("note_strobe_width", {31'd0, prev_nv}, 32'd0);
        if (note_exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_note: got 0x%0h expected no note event at %0t", cur_note, $time);
        end else begin
          exp_note = note_exp_q.pop_front();
          check("note_fields", {13'd0, cur_note}, {13'd0, exp_note});
        end
        last_note = cur_note;
      end else begin
        check("note_hold", {13'd0, cur_note}, {13'd0, last_note});
      end
      prev_rbv = rx_byte_valid | frame_err;
      prev_nv  = note_valid;
    end
  end

  task automatic hold_rx(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  // One frame: start high, 8 bits MSB first, stop, then two idle-low bit times.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    byte_exp_q.push_back(stop_ok ? int'(b) : FERR);
    hold_rx(1'b1, CPB);
    for (int i = 7; i >= 0; i--) hold_rx(b[i], CPB);
    hold_rx(stop_ok, CPB);
    hold_rx(1'b0, 2 * CPB);
  endtask

  task automatic expect_note(input logic on, input logic [3:0] ch, input logic [6:0] k, input logic [6:0] v);
    note_t n;
    n = {on, ch, k, v};
    note_exp_q.push_back(n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_byte"},    {24'd0, rx_byte}, 32'h00);
    check({tag, "_strobes"},    {29'd0, rx_byte_valid, frame_err, note_valid}, 32'd0);
    check({tag, "_note_on"},    {31'd0, note_on}, 32'd0);
    check({tag, "_note_chan"},  {28'd0, note_chan}, 32'd0);
    check({tag, "_note_key"},   {25'd0, note_key}, 32'd0);
    check({tag, "_note_vel"},   {25'd0, note_vel}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 * CPB) @(negedge clk);
    check_reset_outputs("reset");

    // Note On ch0 key 42 vel 51
    expect_note(1'b1, 4'h0, 7'd42, 7'd51);
    send_byte(8'h90, 1'b1); send_byte(8'h2A, 1'b1); send_byte(8'h33, 1'b1);

    // Note Off
    expect_note(1'b0, 4'h0, 7'd42, 7'd51);
    send_byte(8'h80, 1'b1); send_byte(8'h2A, 1'b1); send_byte(8'h33, 1'b1);

    // Note On velocity 0 on ch5 reads as Note Off
    expect_note(1'b0, 4'h5, 7'd60, 7'd0);
    send_byte(8'h95, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1);

    // Realtime byte interleaved mid-message
    expect_note(1'b1, 4'h0, 7'd42, 7'd51);
    send_byte(8'h90, 1'b1); send_byte(8'h2A, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h33, 1'b1);

    // Non-note status abandons the message and clears retained status
    send_byte(8'hB0, 1'b1); send_byte(8'h2A, 1'b1); send_byte(8'h33, 1'b1);

    // Status byte mid-message restarts the parse
    expect_note(1'b0, 4'h0, 7'h10, 7'h20);
    send_byte(8'h90, 1'b1); send_byte(8'h2A, 1'b1);
    send_byte(8'h80, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1);

    // Framing error drops the byte and the parse; following data ignored
    send_byte(8'h90, 1'b0); send_byte(8'h2A, 1'b1); send_byte(8'h33, 1'b1);

    // One-cycle glitch is not a start bit
    hold_rx(1'b1, 1);
    hold_rx(1'b0, 3 * CPB);

    // Running status: second key/velocity pair only counts with the feature
    expect_note(1'b1, 4'h0, 7'd42, 7'd51);
`ifdef MIDI_RUNNING_STATUS_EN
    expect_note(1'b1, 4'h0, 7'd43, 7'd64);
`endif
    send_byte(8'h90, 1'b1); send_byte(8'h2A, 1'b1); send_byte(8'h33, 1'b1);
    send_byte(8'h2B, 1'b1); send_byte(8'h40, 1'b1);

    // Reset mid-message and mid-byte discards everything
    send_byte(8'h90, 1'b1); send_byte(8'h2A, 1'b1);
    hold_rx(1'b1, CPB);
    hold_rx(1'b0, CPB);
    hold_rx(1'b1, CPB);
    hold_rx(1'b1, CPB / 2);
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check_reset_outputs("midreset");
    send_byte(8'h33, 1'b1);

    // Clean message after the reset still works
    expect_note(1'b1, 4'h7, 7'd1, 7'd127);
    send_byte(8'h97, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h7F, 1'b1);

    repeat (4 * CPB) @(negedge clk);
    check("byte_queue_drained", byte_exp_q.size(), 32'd0);
    check("note_queue_drained", note_exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/midi_note_rx.md
# midi_note_rx

Serial MIDI receiver and note-message parser for the synth front end. Takes the raw MIDI line, recovers bytes at 31.25 kbaud, and assembles three-byte Note On / Note Off messages. Presents one registered note event per completed message to the voice logic downstream.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 31_250: MIDI bit rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (1600 at defaults), integer division.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  MIDI serial line, asynchronous to `clk`.
- `rx_byte`  out  8  last received byte (debug).
- `rx_byte_valid`  out  1  one-cycle strobe, `rx_byte` updated.
- `frame_err`  out  1  one-cycle strobe, stop bit sampled low.
- `note_valid`  out  1  one-cycle strobe, note fields updated.
- `note_on`  out  1  1 = note on, 0 = note off.
- `note_chan`  out  4  MIDI channel (status low nibble).
- `note_key`  out  7  key number.
- `note_vel`  out  7  velocity.

## Operation
- Line format: idle low; start bit high; 8 data bits MSB first (bit 7 first); stop bit high; line returns low.
- `rx` passes through a 2-flop synchronizer before any use.
- Byte receiver FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: wait for synchronized 0->1 edge; clear bit counter.
  - START: count `CLKS_PER_BIT/2`; if sample is 0, false start, go to IDLE; else go to DATA.
  - DATA: sample every `CLKS_PER_BIT`, shift left, 8 samples.
  - STOP: sample after `CLKS_PER_BIT`. If 1, strobe `rx_byte_valid`. If 0, strobe `frame_err` and drop the byte. Then go to IDLE. A new start needs a fresh 0->1 edge.
- Parser FSM: WAIT_STATUS -> WAIT_KEY -> WAIT_VEL -> WAIT_STATUS. It runs on `rx_byte_valid` only.
  - Byte 0x80-0x8F: latch off/channel, go to WAIT_KEY. Byte 0x90-0x9F: latch on/channel, go to WAIT_KEY.
  - Byte 0xA0-0xF7 (any other status): abandon the message, go to WAIT_STATUS.
  - Byte 0xF8-0xFF (realtime): ignored; parser state unchanged.
  - Data byte (bit 7 = 0) in WAIT_STATUS: ignored (except under running status; see Configuration). In WAIT_KEY: latch key. In WAIT_VEL: latch velocity, emit event.
  - Status byte arriving in WAIT_KEY or WAIT_VEL restarts the parse from that byte.
  - Note On with velocity 0 is emitted as `note_on=0`, and `note_vel=0`.
- `frame_err` resets the parser to WAIT_STATUS.

## Timing
- Reset: both FSMs idle, counters 0, `rx_byte=0x00`, all strobes 0, `note_on=0`, `note_chan=0`, `note_key=0`, `note_vel=0`.
- Reset asserted mid-byte or mid-message discards everything; the next start edge after release begins cleanly.
- `rx_byte_valid` goes high on the cycle after the stop-bit sample.
- `note_valid` goes high exactly one cycle after the velocity byte's `rx_byte_valid`.
- Note fields change only together with `note_valid`, and hold until the next event.
- Edge-to-sample latency: 2 synchronizer cycles, plus `CLKS_PER_BIT/2` to mid-start, plus `CLKS_PER_BIT` per bit.
- Strobes are never asserted for more than one cycle.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - The last Note On/Off status is retained after an event.
  - A data byte in WAIT_STATUS is taken as the key under that status; the parser goes to WAIT_VEL.
  - Retained status is cleared by reset, any non-realtime non-note status byte, or `frame_err`.
- Undefined: data bytes in WAIT_STATUS are always ignored.

## Test plan
- Reset release, line held low for 10 bit periods -> all outputs at reset values, no strobes.
- Send 0x90, 0x2A, 0x33 -> three `rx_byte_valid` strobes; then `note_valid` with on=1, chan=0, key=42, vel=51.
- Send 0x80, 0x2A, 0x33 -> `note_valid` with on=0, key=42, vel=51. Send 0x95, 0x3C, 0x00 -> on=0, chan=5, key=60, vel=0.
- Send 0x90, 0x2A, 0xF8, 0x33 -> realtime byte ignored; one event, key=42, vel=51.
- Send frame 0x90 with stop bit low -> `frame_err` strobe, no `rx_byte_valid`. A following 0x2A, 0x33 produces no event. A 1-cycle-wide high glitch on `rx` -> no byte received.
- With `MIDI_RUNNING_STATUS_EN`: send 0x90, 0x2A, 0x33, 0x2B, 0x40 -> two events, keys 42 and 43. Without the macro -> one event only.
